// File: rtl/regfile_sb.sv
// Parametrised register file with per-register pending scoreboard and a sequenced bulk-clear engine.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_ready,
  output logic            rs2_ready,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            clr_req,
  output logic            clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [AW-1:0]      r_cnt;
  logic [XLEN-1:0]    r_mem [NREGS];
  logic [NREGS-1:0]   r_pending;
  logic               w_idle;
  logic               w_wrOk;
  logic               w_issueOk;
  logic               w_lastClr;

  assign w_idle    = (r_state == IDLE);
  assign w_wrOk    = w_idle && wr_en && (wr_addr != '0);
  assign w_issueOk = w_idle && issue_en && (issue_rd != '0);
  assign w_lastClr = (r_cnt == AW'(NREGS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (clr_req) w_stateNext = CLEAR;
      CLEAR:   if (w_lastClr) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (r_state == CLEAR);
  end

  // Counter walks 1..NREGS-1; x0 is never stored so the sweep skips it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_idle) begin
      if (clr_req) r_cnt <= AW'(1);
    end else if (w_lastClr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (!w_idle) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wrOk) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Issue is applied after writeback so a same-cycle pair leaves the new producer pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else if (w_idle && clr_req) begin
      r_pending <= '0;
    end else begin
      if (w_wrOk)    r_pending[wr_addr]  <= 1'b0;
      if (w_issueOk) r_pending[issue_rd] <= 1'b1;
    end
  end

  always_comb begin
    rs1_data  = r_mem[rs1_addr];
    rs2_data  = r_mem[rs2_addr];
    rs1_ready = !r_pending[rs1_addr] && !clr_busy;
    rs2_ready = !r_pending[rs2_addr] && !clr_busy;
`ifdef REGFILE_BYPASS_EN
    if (w_wrOk && (wr_addr == rs1_addr)) begin
      rs1_data  = wr_data;
      rs1_ready = (issue_en && (issue_rd == wr_addr)) ? !r_pending[rs1_addr] : 1'b1;
    end
    if (w_wrOk && (wr_addr == rs2_addr)) begin
      rs2_data  = wr_data;
      rs2_ready = (issue_en && (issue_rd == wr_addr)) ? !r_pending[rs2_addr] : 1'b1;
    end
`endif
    if (rs1_addr == '0) begin
      rs1_data  = '0;
      rs1_ready = 1'b1;
    end
    if (rs2_addr == '0) begin
      rs2_data  = '0;
      rs2_ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a 32x32 instance plus a 64-bit, 16-entry instance.
// Expected read results are queued when stimulus is driven and popped when outputs are sampled.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [63:0] data;
    logic        ready;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        rs1_ready, rs2_ready, wr_en, issue_en, clr_req, clr_busy;

  logic [3:0]  b_rs1_addr, b_rs2_addr, b_wr_addr, b_issue_rd;
  logic [63:0] b_rs1_data, b_rs2_data, b_wr_data;
  logic        b_rs1_ready, b_rs2_ready, b_wr_en, b_issue_en, b_clr_req, b_clr_busy;

  exp_t sbq[$];
  exp_t e;
  int   nChecks = 0;
  int   nFails  = 0;

  regfile_sb #(.XLEN(32), .NREGS(32)) dutA (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_sb #(.XLEN(64), .NREGS(16)) dutB (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_ready(b_rs1_ready), .rs2_ready(b_rs2_ready),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .issue_en(b_issue_en), .issue_rd(b_issue_rd),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs1_addr   = 5'(a);
      rs2_addr   = 5'(31 - a);
      b_rs1_addr = 4'(a);
      sbq.push_back('{"reset_rs1", 64'h0, 1'b1});
      sbq.push_back('{"reset_rs2", 64'h0, 1'b1});
      sbq.push_back('{"reset_b_rs1", 64'h0, 1'b1});
      #1;
      e = sbq.pop_front(); nChecks++;
      if (rs1_data !== e.data[31:0] || rs1_ready !== e.ready) begin
        nFails++;
        $display("[TB] FAIL %s addr %0d: data=%h ready=%b, expected data=%h ready=%b",
                 e.name, a, rs1_data, rs1_ready, e.data[31:0], e.ready);
      end
      e = sbq.pop_front(); nChecks++;
      if (rs2_data !== e.data[31:0] || rs2_ready !== e.ready) begin
        nFails++;
        $display("[TB] FAIL %s addr %0d: data=%h ready=%b, expected data=%h ready=%b",
                 e.name, 31 - a, rs2_data, rs2_ready, e.data[31:0], e.ready);
      end
      e = sbq.pop_front(); nChecks++;
      if (b_rs1_data !== e.data || b_rs1_ready !== e.ready) begin
        nFails++;
        $display("[TB] FAIL %s addr %0d: data=%h ready=%b, expected data=%h ready=%b",
                 e.name, a % 16, b_rs1_data, b_rs1_ready, e.data, e.ready);
      end
      @(negedge clk);
    end
    nChecks++;
    if (clr_busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_busy: clr_busy=%b, expected 0", clr_busy);
    end
  endtask

  task automatic test_x0();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    rs1_addr = 5'd0;
    sbq.push_back('{"x0_write_discarded", 64'h0, 1'b1});
    #1;
    e = sbq.pop_front(); nChecks++;
    if (rs1_data !== e.data[31:0] || rs1_ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               e.name, rs1_data, rs1_ready, e.data[31:0], e.ready);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000000A;
    rs2_addr = 5'd5;
    sbq.push_back('{"write_same_cycle", BYP ? 64'hA : 64'h0, 1'b1});
    #1;
    e = sbq.pop_front(); nChecks++;
    if (rs2_data !== e.data[31:0] || rs2_ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               e.name, rs2_data, rs2_ready, e.data[31:0], e.ready);
    end
    tick();
    wr_en = 1'b0;
    rs1_addr = 5'd5;
    sbq.push_back('{"write_next_cycle", 64'hA, 1'b1});
    #1;
    e = sbq.pop_front(); nChecks++;
    if (rs1_data !== e.data[31:0] || rs1_ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               e.name, rs1_data, rs1_ready, e.data[31:0], e.ready);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    issue_en = 1'b0;
    rs1_addr = 5'd7;
    sbq.push_back('{"issue_pending", 64'h0, 1'b0});
    sbq.push_back('{"wb_same_cycle", BYP ? 64'h1234 : 64'h0, BYP});
    sbq.push_back('{"wb_next_cycle", 64'h1234, 1'b1});
    sbq.push_back('{"issue_wb_same_cycle", 64'h1234, 1'b1});
    sbq.push_back('{"issue_wins", 64'h1234, 1'b0});
    for (int step = 0; step < 4; step++) begin
      case (step)
        1: begin wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234; end
        3: begin wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
                 issue_en = 1'b1; issue_rd = 5'd7; end
        default: ;
      endcase
      #1;
      e = sbq.pop_front(); nChecks++;
      if (rs1_data !== e.data[31:0] || rs1_ready !== e.ready) begin
        nFails++;
        $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
                 e.name, rs1_data, rs1_ready, e.data[31:0], e.ready);
      end
      tick();
      wr_en = 1'b0; issue_en = 1'b0;
    end
    #1;
    e = sbq.pop_front(); nChecks++;
    if (rs1_data !== e.data[31:0] || rs1_ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               e.name, rs1_data, rs1_ready, e.data[31:0], e.ready);
    end
  endtask

  task automatic test_bulk_clear();
    int cnt;
    @(negedge clk);
    for (int r = 1; r < 32; r++) begin
      wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'h1000 + 32'(r);
      tick();
    end
    wr_en = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd3;
    tick();
    issue_en = 1'b0;
    rs1_addr = 5'd31;
    sbq.push_back('{"preload_x31", 64'h101F, 1'b1});
    #1;
    e = sbq.pop_front(); nChecks++;
    if (rs1_data !== e.data[31:0] || rs1_ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               e.name, rs1_data, rs1_ready, e.data[31:0], e.ready);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      if (cnt == 0) begin
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF;
        issue_en = 1'b1; issue_rd = 5'd10; clr_req = 1'b1;
        rs2_addr = 5'd20;
        #1;
        nChecks++;
        if (rs2_ready !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL clear_ready_low: rs2_ready=%b, expected 0", rs2_ready);
        end
      end
      cnt++;
      tick();
      wr_en = 1'b0; issue_en = 1'b0; clr_req = 1'b0;
    end
    nChecks++;
    if (cnt != 31) begin
      nFails++;
      $display("[TB] FAIL clear_length: busy cycles=%0d, expected 31", cnt);
    end
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r);
      sbq.push_back('{"after_clear", 64'h0, 1'b1});
      #1;
      e = sbq.pop_front(); nChecks++;
      if (rs1_data !== e.data[31:0] || rs1_ready !== e.ready) begin
        nFails++;
        $display("[TB] FAIL %s x%0d: data=%h ready=%b, expected data=%h ready=%b",
                 e.name, r, rs1_data, rs1_ready, e.data[31:0], e.ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h55;
    tick();
    wr_addr = 5'd25; wr_data = 32'h66;
    tick();
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    rs1_addr = 5'd20; rs2_addr = 5'd25;
    #1;
    nChecks++;
    if (clr_busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL abort_busy: clr_busy=%b, expected 0", clr_busy);
    end
    sbq.push_back('{"abort_x20", 64'h0, 1'b1});
    sbq.push_back('{"abort_x25", 64'h0, 1'b1});
    e = sbq.pop_front(); nChecks++;
    if (rs1_data !== e.data[31:0] || rs1_ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               e.name, rs1_data, rs1_ready, e.data[31:0], e.ready);
    end
    e = sbq.pop_front(); nChecks++;
    if (rs2_data !== e.data[31:0] || rs2_ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               e.name, rs2_data, rs2_ready, e.data[31:0], e.ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    nChecks++;
    if (cnt != 31) begin
      nFails++;
      $display("[TB] FAIL fresh_clear_length: busy cycles=%0d, expected 31", cnt);
    end
  endtask

  task automatic test_param();
    int cnt;
    @(negedge clk);
    b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'hFFFF_0000_FFFF_0000;
    tick();
    b_wr_en = 1'b0;
    b_rs1_addr = 4'd15; b_rs2_addr = 4'd15;
    sbq.push_back('{"wide_x15", 64'hFFFF_0000_FFFF_0000, 1'b1});
    #1;
    e = sbq.pop_front(); nChecks++;
    if (b_rs1_data !== e.data || b_rs1_ready !== e.ready || b_rs2_data !== e.data) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h/%h ready=%b, expected data=%h ready=%b",
               e.name, b_rs1_data, b_rs2_data, b_rs1_ready, e.data, e.ready);
    end
    b_clr_req = 1'b1;
    tick();
    b_clr_req = 1'b0;
    cnt = 0;
    while (b_clr_busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    nChecks++;
    if (cnt != 15) begin
      nFails++;
      $display("[TB] FAIL wide_clear_length: busy cycles=%0d, expected 15", cnt);
    end
    sbq.push_back('{"wide_after_clear", 64'h0, 1'b1});
    #1;
    e = sbq.pop_front(); nChecks++;
    if (b_rs1_data !== e.data || b_rs1_ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               e.name, b_rs1_data, b_rs1_ready, e.data, e.ready);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0; clr_req = 1'b0;
    b_rs1_addr = '0; b_rs2_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_issue_en = 1'b0; b_issue_rd = '0; b_clr_req = 1'b0;
    test_reset();
    test_x0();
    test_write_read();
    test_scoreboard();
    test_bulk_clear();
    test_reset_mid_clear();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle core's 32x32 register file.
- Adds configurable width and depth, and a per-register pending scoreboard for the upcoming multi-cycle and pipelined datapath.
- Adds a sequenced bulk-clear engine that replaces the old hard-coded reset preload.
- Two combinational read ports, one synchronous write port.
- Sits between the decode stage (read and issue) and the writeback stage (write).

Parameters:
- XLEN, 32, data width of each register in bits.
- NREGS, 32, number of architectural registers; power of 2, at least 4.
- AW, $clog2(NREGS), localparam: register address width. Not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rs1_data  output  XLEN  read port 1 data (combinational).
- rs2_data  output  XLEN  read port 2 data (combinational).
- rs1_ready  output  1  high when register rs1_addr has no pending producer.
- rs2_ready  output  1  high when register rs2_addr has no pending producer.
- wr_en  input  1  writeback enable.
- wr_addr  input  AW  writeback register address.
- wr_data  input  XLEN  writeback data.
- issue_en  input  1  marks register issue_rd as pending (new producer in flight).
- issue_rd  input  AW  destination of the issuing instruction.
- clr_req  input  1  single-cycle request to zero all registers.
- clr_busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers 0; all pending bits 0; FSM in IDLE; clear counter 0; clr_busy 0.
  - After reset: rsX_data = 0, rsX_ready = 1.
- Register 0 is hardwired:
  - Reads always return 0 with ready = 1.
  - Writes to it are discarded; issue to it never sets pending.
- Read path is combinational: rsX_data = mem[rsX_addr]; rsX_ready = !pending[rsX_addr] && !clr_busy.
- Write: at the rising edge with wr_en = 1, FSM in IDLE and wr_addr != 0:
  - mem[wr_addr] <= wr_data;
  - pending[wr_addr] <= 0.
- Issue: at the rising edge with issue_en = 1, FSM in IDLE and issue_rd != 0: pending[issue_rd] <= 1.
- Same-cycle write and issue to the same address: the data is written and pending ends at 1 (issue wins; the new producer is outstanding).
- Write to a non-pending register is legal and leaves pending at 0.
- FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req = 1. On the same edge: all pending bits <= 0, counter <= 1.
  - CLEAR: each cycle mem[counter] <= 0 and counter increments.
  - When counter == NREGS-1, that register is cleared and the FSM returns to IDLE.
  - clr_busy is high from the cycle after clr_req through the last clearing edge: exactly NREGS-1 cycles.
  - In CLEAR: wr_en, issue_en and clr_req are ignored.
  - Reads during CLEAR return current storage, which may be partially cleared; rsX_ready = 0.
- Counter is AW bits wide and never wraps: the CLEAR exit occurs at NREGS-1.
- reset_n asserted mid-CLEAR aborts immediately to the reset state.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_en = 1, FSM in IDLE, wr_addr != 0 and wr_addr == rsX_addr, then in the same cycle rsX_data = wr_data and rsX_ready = 1, combinationally.
  - Exception: if issue_en targets the same address in that cycle, rsX_ready follows the stored pending bit.
- Undefined:
  - rsX_data shows the old value until the edge.
  - rsX_ready reflects the stored pending bit only, so it goes high the cycle after writeback.

Test Plan:
- Reset and x0:
  - Release reset_n; read all addresses -> data 0, ready 1.
  - Write x0 = 32'hDEADBEEF -> rs1_addr = 0 still reads 0.
- Write then read:
  - Write x5 = 32'h0000000A; next cycle rs1_addr = 5 -> 32'h0000000A, ready 1.
  - Same cycle, rs2_addr = 5 reads old value 0 without the macro, or 32'h0000000A with REGFILE_BYPASS_EN.
- Scoreboard:
  - issue_rd = 7 -> next cycle rs1_addr = 7 gives ready 0.
  - Write x7 = 32'h1234 -> ready 1 next cycle (same cycle with bypass).
  - Simultaneous issue and write to x7 -> ready stays 0, data 32'h1234.
- Bulk clear (NREGS = 32):
  - Preload x1..x31 with nonzero values, pend x3, pulse clr_req.
  - clr_busy high exactly 31 cycles; wr_en to x9 during CLEAR ignored.
  - After completion all registers read 0 and all ready = 1.
- Reset mid-clear:
  - Assert reset_n low 10 cycles into CLEAR -> clr_busy 0 immediately, all registers 0.
  - Next clr_req starts a fresh 31-cycle sequence.
- Parametrisation: XLEN = 64, NREGS = 16; write x15 = 64'hFFFF_0000_FFFF_0000 -> reads back exactly; clear takes 15 cycles.
